// File: rtl/data_mem_pkg.sv
// Shared encodings for the load/store data memory: access sizes, FSM states
// and the lane sign/zero extension helper.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Widen a byte (half=0, uses lane[7:0]) or halfword (half=1) to 32 bits.
  function automatic logic [31:0] ext_lane(input logic [15:0] lane,
                                           input logic half,
                                           input logic zero_ext);
    if (half)
      return {(zero_ext ? 16'h0000 : {16{lane[15]}}), lane};
    else
      return {(zero_ext ? 24'h000000 : {24{lane[7]}}), lane[7:0]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// word, load lane extraction with extension, and size/alignment checking.
module lsu_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rvalue,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Store path: data is replicated across lanes so byte_en alone picks the target.
  always_comb begin
    byte_en  = 4'b0000;
    wword    = wdata;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Load path: pick the little-endian lane, then extend; words pass straight through.
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rword[7:0];
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      default: lane_b = rword[31:24];
    endcase
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: rvalue = ext_lane({8'h00, lane_b}, 1'b0, unsigned_ld);
      SZ_HALF: rvalue = ext_lane(lane_h, 1'b1, unsigned_ld);
      default: rvalue = rword;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with MIPS load/store sizing, a req/ready
// handshake, programmable wait states and error reporting.
module data_memory_lsu
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 15,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              ack,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [1:0]        state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       mem_q;

  logic [31:0]       mem [0:DEPTH-1];

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              out_of_range;
  logic              misalign;
  logic              bad;
  logic              access;
  logic [3:0]        byte_en;
  logic [31:0]       wword;
  logic [31:0]       rvalue;
  logic [31:0]       load_value;

  assign word_idx     = addr_reg[ADDR_W-1:2];
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign out_of_range = (32'(word_idx) >= DEPTH_U);
  assign bad          = misalign | out_of_range;
  assign access       = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);

  lsu_lane_align u_align (
    .size        (size_reg),
    .addr_lo     (addr_reg[1:0]),
    .unsigned_ld (uns_reg),
    .wdata       (wdata_reg),
    .rword       (mem_q),
    .byte_en     (byte_en),
    .wword       (wword),
    .rvalue      (rvalue),
    .misalign    (misalign)
  );

  assign load_value = bad ? 32'h0000_0000 : rvalue;

  // FSM, wait counter, request latch and held load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      size_reg  <= SZ_BYTE;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            we_reg    <= we;
            size_reg  <= size;
            uns_reg   <= unsigned_ld;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            cnt_reg   <= 4'(WAIT);
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
          else                 state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (!we_reg) rdata_reg <= load_value;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Word storage: byte-masked write and registered read, both on the access edge.
  always_ff @(posedge clk) begin
    if (access) begin
      if (we_reg && !bad) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[mem_idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
      mem_q <= mem[mem_idx];
    end
  end

  // During RESP a load shows the fresh result; otherwise the last completed load is held.
  assign ready  = (state_reg == ST_IDLE);
  assign ack    = (state_reg == ST_RESP);
  assign rvalid = ack & ~we_reg;
  assign err    = ack & bad;
  assign rdata  = (ack && !we_reg) ? load_value : rdata_reg;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: directed scenarios plus random
// traffic against a byte-array reference model.
module tb_data_memory_lsu;
  import data_mem_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 11;
  localparam int WAIT   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              unsigned_ld = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = 32'h0;
  logic              ready;
  logic              ack;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  model_bytes [0:4*DEPTH-1];
  logic [31:0] model_rdata = 32'h0;

  data_memory_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT(WAIT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .ack         (ack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules stated on byte addresses.
  function automatic logic model_err(input logic [1:0] sz, input int a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input int a);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(model_bytes[a+i]) << (8*i));
    if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++) model_bytes[a+i] = 8'(d >> (8*i));
  endtask

  // rst_mode: 0 normal, 1 reset while BUSY, 2 reset while RESP.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input int a, input logic [31:0] d, input int rst_mode);
    int k = 0;
    int guard = 0;
    int seen = 0;
    logic exp_err;
    logic [31:0] exp_rd;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    exp_err = model_err(sz, a);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = ADDR_W'(a); wdata = d;
    @(posedge clk);
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_ready", 32'(ready), 32'd0);
      if (rst_mode == 1 && k == 2) begin
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk("rst_busy_ack", 32'(ack), 32'd0);
        chk("rst_busy_ready", 32'(ready), 32'd1);
        chk("rst_busy_rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WAIT + 3) begin
          @(negedge clk);
          if (ack) seen++;
        end
        chk("rst_busy_noack", 32'(seen), 32'd0);
        $display("txn ST/LD aborted by reset addr=%h", a);
        return;
      end
      if (!ack) begin
        req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
        unsigned_ld = 1'($urandom); addr = ADDR_W'($urandom); wdata = $urandom;
      end
    end while (!ack && k < 40);
    req = 1'b0;
    chk("latency", 32'(k), 32'(WAIT + 2));
    if (!ack) return;
    if (w && !exp_err) model_store(sz, a, d);
    exp_rd = w ? model_rdata : (exp_err ? 32'h0 : model_load(sz, u, a));
    chk("err", 32'(err), 32'(exp_err));
    chk("rvalid", 32'(rvalid), 32'(!w));
    chk("rdata", rdata, exp_rd);
    $display("txn %s sz=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h",
             w ? "ST" : "LD", sz, u, a, d, err, rdata);
    if (rst_mode == 2) begin
      rst_n = 1'b0;
      #1;
      chk("rst_resp_ack", 32'(ack), 32'd0);
      chk("rst_resp_rvalid", 32'(rvalid), 32'd0);
      chk("rst_resp_err", 32'(err), 32'd0);
      chk("rst_resp_rdata", rdata, 32'h0);
      chk("rst_resp_ready", 32'(ready), 32'd1);
      model_rdata = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (!w) model_rdata = exp_rd;
    @(negedge clk);
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    #2;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill every word so the model is fully defined.
    for (int i = 0; i < DEPTH; i++) access(1'b1, SZ_WORD, 1'b0, i * 4, $urandom, 0);

    // Lane selection and extension.
    access(1'b1, SZ_WORD, 1'b0, 'h10, 32'h1234_5678, 0);
    access(1'b0, SZ_BYTE, 1'b0, 'h11, 32'h0, 0);
    access(1'b0, SZ_HALF, 1'b0, 'h12, 32'h0, 0);
    access(1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, 0);
    access(1'b1, SZ_WORD, 1'b0, 'h20, 32'h0, 0);
    access(1'b1, SZ_BYTE, 1'b0, 'h23, 32'h0000_00F0, 0);
    access(1'b0, SZ_WORD, 1'b0, 'h20, 32'h0, 0);
    access(1'b0, SZ_BYTE, 1'b0, 'h23, 32'h0, 0);
    access(1'b0, SZ_BYTE, 1'b1, 'h23, 32'h0, 0);
    access(1'b0, SZ_HALF, 1'b1, 'h22, 32'h0, 0);

    // Error cases.
    access(1'b1, SZ_HALF, 1'b0, 'h05, 32'hAAAA_BBBB, 0);
    access(1'b0, SZ_WORD, 1'b0, 'h04, 32'h0, 0);
    access(1'b0, SZ_WORD, 1'b0, 'h06, 32'h0, 0);
    access(1'b0, SZ_RSVD, 1'b0, 'h08, 32'h0, 0);
    access(1'b1, SZ_WORD, 1'b0, DEPTH * 4, 32'hCAFE_F00D, 0);
    access(1'b0, SZ_WORD, 1'b0, DEPTH * 4, 32'h0, 0);
    access(1'b0, SZ_WORD, 1'b0, 'h00, 32'h0, 0);

    // Reset in RESP, then earlier data still readable.
    access(1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, 2);
    access(1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, 0);

    // Reset in BUSY aborts the store.
    access(1'b1, SZ_WORD, 1'b0, 'h40, 32'hDEAD_BEEF, 1);
    access(1'b0, SZ_WORD, 1'b0, 'h40, 32'h0, 0);

    // Random traffic, mostly in range.
    for (int i = 0; i < 250; i++) begin
      int a;
      logic [1:0] sz;
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4 * DEPTH, 2 ** ADDR_W - 1))
                                       : int'($urandom_range(0, 4 * DEPTH - 1));
      sz = ($urandom_range(0, 9) == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
      access(1'($urandom), sz, 1'($urandom), a, $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
